vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Consumer end of the 100 MHz → 25 MHz pixel-rate path for 640x480 @ 60 Hz.
- Runs entirely on Clk_100M and generates its own pixel-rate enable (p_tick) instead of using a derived clock.
- Produces hsync/vsync, the visible-area flag and pixel coordinates.
- Feeds the Game-of-Life renderer and the generation-update logic (frame_end).

Parameters:
- CLK_PER_PIX, 4, Clk_100M cycles per pixel (100 MHz / 25 MHz)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk_100M  in  1  system clock, 100 MHz
- Reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current row, 0..V_TOTAL-1
- p_tick  out  1  one Clk_100M-cycle pulse, once per pixel period
- frame_end  out  1  one-cycle pulse coincident with p_tick on the last pixel of the frame

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Clocking: one clock (Clk_100M). Reset is synchronous and active-high. Every register uses the Reset-has-priority rule.
- Pixel divider counter:
  - Counts 0..CLK_PER_PIX-1 and wraps to 0.
  - p_tick = 1 exactly when the divider is at CLK_PER_PIX-1, giving a 25% duty pulse every 4 cycles.
- Horizontal counter h:
  - Advances only on p_tick.
  - At h = H_TOTAL-1 it wraps to 0 and v advances.
- Vertical counter v:
  - Advances only when h wraps.
  - At v = V_TOTAL-1 it wraps to 0.
- Decode, registered on the same edge as the counter update so outputs align with pixel_x/pixel_y:
  - hsync = 0 iff H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
  - pixel_x = h, pixel_y = v.
- frame_end = p_tick && h == 799 && v == 524. On the next cycle h = v = 0 and the new frame begins.
- Reset values, held while Reset = 1 and present on the first cycle after release:
  - divider = 0, h = v = 0
  - pixel_x = pixel_y = 0
  - hsync = 1, vsync = 1, video_on = 1
  - p_tick = 0, frame_end = 0
- After release, the first p_tick occurs on the 4th rising edge (divider 0→3).
- Reset mid-frame or mid-sync: on the next edge all counters and outputs take their reset values. No partial sync pulse is extended; hsync/vsync return high immediately.
- Timing figures:
  - Line period = 3200 cycles; hsync low = 384 cycles.
  - Frame period = 1,680,000 cycles; vsync low = 6400 cycles.
- Counters are sized to 10 bits and never exceed TOTAL-1; no overflow path exists.
- No inputs other than Clk_100M and Reset; there are no simultaneous-event cases beyond the h/v wrap, which is handled as described above.

Decomposition:
- vga_timing_pkg holds the porch/sync/display constants, H_TOTAL, V_TOTAL, CLK_PER_PIX and the coordinate width (10).
- One sub-module, pix_tick_gen: the CLK_PER_PIX divider producing p_tick, with Clk_100M and Reset.
- vga_sync instantiates pix_tick_gen and contains the h/v counters and the output decode.

Test Plan:
- Assert Reset for 5 cycles, then release → outputs at reset values; first p_tick on the 4th edge after release; pixel_x = 1 on the cycle after that tick.
- Run one line → p_tick spacing = 4 cycles; hsync falls when pixel_x = 656 and rises at 752; low width 384 cycles; line length 3200 cycles; video_on low from pixel_x = 640 to 799.
- Run one full frame → vsync low only while pixel_y ∈ {490, 491} (6400 cycles); exactly one frame_end, 1,680,000 cycles after the previous frame start; pixel_x = pixel_y = 0 on the cycle after frame_end.
- Check visible count per frame → video_on asserted on exactly 640×480 = 307,200 p_tick cycles.
- Assert Reset for 1 cycle while pixel_x = 700 (hsync low) and pixel_y = 491 (vsync low) → hsync = vsync = 1 on the next cycle; counters at 0; normal timing resumes from frame start.
- Run two consecutive frames → frame_end period is exactly 1,680,000 cycles; pixel_x never exceeds 799 and pixel_y never exceeds 524.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz timing constants shared by the VGA sync path.
package vga_timing_pkg;

    localparam int CLK_PER_PIX = 4;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test used for the sync pulse decode.
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable: one-cycle p_tick every DIV system clocks.
module pix_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV = CLK_PER_PIX
) (
    input  logic Clk_100M,
    input  logic Reset,
    output logic p_tick
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator on the 100 MHz clock: h/v counters stepped by p_tick,
// with sync/visible decode registered alongside the counters.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_PER_PIX = vga_timing_pkg::CLK_PER_PIX,
    parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BACK      = vga_timing_pkg::V_BACK
) (
    input  logic               Clk_100M,
    input  logic               Reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               p_tick,
    output logic               frame_end
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hsync_q, vsync_q, video_on_q;

    pix_tick_gen #(
        .DIV (CLK_PER_PIX)
    ) u_pix_tick_gen (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .p_tick   (p_tick)
    );

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode from the next-state counters so flags line up with pixel_x/pixel_y.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= !in_window(h_d, HS_START, HS_END);
            vsync_q    <= !in_window(v_d, VS_START, VS_END);
            video_on_q <= (h_d < H_VIS) && (v_d < V_VIS);
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign pixel_x   = h_q;
    assign pixel_y   = v_q;
    assign frame_end = p_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench: a full-size instance for line timing and a shrunken
// instance so whole frames fit in a short run.
module tb_vga_sync;

    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       fe;
    } obs_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;

    logic       hs_b, vs_b, von_b, pt_b, fe_b;
    logic [9:0] px_b, py_b;
    logic       hs_s, vs_s, von_s, pt_s, fe_s;
    logic [9:0] px_s, py_s;

    always #5 clk = ~clk;

    vga_sync dut_b (
        .Clk_100M (clk), .Reset (rst_b),
        .hsync (hs_b), .vsync (vs_b), .video_on (von_b),
        .pixel_x (px_b), .pixel_y (py_b),
        .p_tick (pt_b), .frame_end (fe_b)
    );

    vga_sync #(
        .CLK_PER_PIX (4),
        .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) dut_s (
        .Clk_100M (clk), .Reset (rst_s),
        .hsync (hs_s), .vsync (vs_s), .video_on (von_s),
        .pixel_x (px_s), .pixel_y (py_s),
        .p_tick (pt_s), .frame_end (fe_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_b      = 0;
    int n_s      = 0;
    obs_t q_b[$];
    obs_t q_s[$];

    int   hs_fall[$];
    int   hs_rise[$];
    int   fall_x = -1, rise_x = -1;
    int   off_cnt = 0, off_line = -1;
    logic prev_hs_b = 1'b1;

    int fe_cyc[$];
    int vis_s = 0, vis_last = -1;
    int vsl_s = 0, vsl_last = -1;
    int max_x = 0, max_y = 0;

    // Expected outputs n clocks after reset release, from absolute time.
    function automatic obs_t model(input int n, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb);
        obs_t o;
        int ht, vt, pix, h, v;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        pix = n / 4;
        h   = pix % ht;
        v   = (pix / ht) % vt;
        o.hs  = !((h >= hd + hf) && (h < hd + hf + hsw));
        o.vs  = !((v >= vd + vf) && (v < vd + vf + vsw));
        o.von = (h < hd) && (v < vd);
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.pt  = (n % 4) == 3;
        o.fe  = o.pt && (h == ht - 1) && (v == vt - 1);
        return o;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        obs_t got, exp;
        n_b = rst_b ? 0 : n_b + 1;
        n_s = rst_s ? 0 : n_s + 1;
        q_b.push_back(model(n_b, 640, 16, 96, 48, 480, 10, 2, 33));
        q_s.push_back(model(n_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
        @(posedge clk);
        #1;
        cyc++;

        got = {hs_b, vs_b, von_b, px_b, py_b, pt_b, fe_b};
        exp = q_b.pop_front();
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL big_outputs cyc=%0d got=%h expected=%h", cyc, got, exp);
        end

        got = {hs_s, vs_s, von_s, px_s, py_s, pt_s, fe_s};
        exp = q_s.pop_front();
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL small_outputs cyc=%0d got=%h expected=%h", cyc, got, exp);
        end

        if (prev_hs_b && !hs_b) begin
            hs_fall.push_back(cyc);
            fall_x   = int'(px_b);
            off_line = off_cnt;
            off_cnt  = 0;
        end
        if (!prev_hs_b && hs_b) begin
            hs_rise.push_back(cyc);
            rise_x = int'(px_b);
        end
        prev_hs_b = hs_b;
        if (pt_b && !von_b) off_cnt++;

        if (pt_s && von_s) vis_s++;
        if (!vs_s) vsl_s++;
        if (int'(px_s) > max_x) max_x = int'(px_s);
        if (int'(py_s) > max_y) max_y = int'(py_s);
        if (fe_s) begin
            fe_cyc.push_back(cyc);
            vis_last = vis_s;
            vis_s    = 0;
            vsl_last = vsl_s;
            vsl_s    = 0;
        end
    endtask

    initial begin
        int rel;

        repeat (5) step();
        rst_b = 1'b0;
        rst_s = 1'b0;
        chk("rel_hsync", int'(hs_b), 1);
        chk("rel_vsync", int'(vs_b), 1);
        chk("rel_video_on", int'(von_b), 1);
        chk("rel_pixel_x", int'(px_b), 0);
        chk("rel_pixel_y", int'(py_b), 0);
        chk("rel_p_tick", int'(pt_b), 0);
        chk("rel_frame_end", int'(fe_b), 0);

        repeat (3) step();
        chk("first_tick_high", int'(pt_b), 1);
        chk("first_tick_x", int'(px_b), 0);
        step();
        chk("after_tick_x", int'(px_b), 1);
        chk("after_tick_p_tick", int'(pt_b), 0);

        // One full line on the 640x480 instance.
        hs_fall.delete();
        hs_rise.delete();
        for (int k = 0; k < 7000 && hs_fall.size() < 2; k++) step();
        chk("two_hs_falls", hs_fall.size(), 2);
        chk("hs_fall_x", fall_x, 656);
        chk("hs_rise_x", rise_x, 752);
        chk("hs_low_cycles", (hs_fall.size() >= 1 && hs_rise.size() >= 1) ? hs_rise[0] - hs_fall[0] : -1, 384);
        chk("line_cycles", (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1, 3200);
        chk("line_blank_ticks", off_line, 160);

        // Reset while hsync is low, then timing restarts from frame start.
        for (int k = 0; k < 4000 && px_b != 10'd700; k++) step();
        chk("big_x_700", int'(px_b), 700);
        chk("big_hs_low_700", int'(hs_b), 0);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        chk("big_rst_hsync", int'(hs_b), 1);
        chk("big_rst_x", int'(px_b), 0);
        chk("big_rst_video_on", int'(von_b), 1);
        rel = cyc;
        hs_fall.delete();
        for (int k = 0; k < 3000 && hs_fall.size() < 1; k++) step();
        chk("resume_fall_delay", (hs_fall.size() >= 1) ? hs_fall[0] - rel : -1, 2624);

        // Small instance: reset inside both sync pulses.
        for (int k = 0; k < 1600 && !(py_s == 10'd9 && px_s == 10'd11); k++) step();
        chk("small_hs_low", int'(hs_s), 0);
        chk("small_vs_low", int'(vs_s), 0);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        chk("small_rst_hsync", int'(hs_s), 1);
        chk("small_rst_vsync", int'(vs_s), 1);
        chk("small_rst_x", int'(px_s), 0);
        chk("small_rst_y", int'(py_s), 0);
        rel = cyc;
        fe_cyc.delete();
        vis_s = 0;
        vsl_s = 0;
        max_x = 0;
        max_y = 0;

        for (int k = 0; k < 3000 && fe_cyc.size() < 3; k++) step();
        chk("three_frame_ends", fe_cyc.size(), 3);
        chk("first_fe_delay", (fe_cyc.size() >= 1) ? fe_cyc[0] - rel : -1, 779);
        chk("frame_period_1", (fe_cyc.size() >= 2) ? fe_cyc[1] - fe_cyc[0] : -1, 780);
        chk("frame_period_2", (fe_cyc.size() >= 3) ? fe_cyc[2] - fe_cyc[1] : -1, 780);
        chk("visible_ticks", vis_last, S_HD * S_VD);
        chk("vsync_low_cycles", vsl_last, S_VS * 15 * 4);
        chk("max_pixel_x", max_x, 14);
        chk("max_pixel_y", max_y, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
